// File: rtl/scanline_tile_sequencer_if.sv
// Handshake bundle between the scanline tile sequencer, the load-section
// fetch FSM, the 8-pixel renderer and the frame/line timing source.
interface scanline_tile_sequencer_if;
    logic       frame_start;
    logic       line_start;
    logic [8:0] line_row;
    logic [7:0] ppu_ctrl2;
    logic       fetch_req;
    logic [4:0] fetch_tile;
    logic [8:0] fetch_row;
    logic       fetch_done;
    logic       render_start;
    logic [8:0] render_row;
    logic [8:0] render_col;
    logic       render_busy;
    logic       sprite_0_hit_in;
    logic       sprite_1_hit_in;
    logic       busy;
    logic       line_done;
    logic       sprite_0_flag;
    logic       sprite_1_flag;

    modport master (
        input  frame_start, line_start, line_row, ppu_ctrl2, fetch_done,
               render_busy, sprite_0_hit_in, sprite_1_hit_in,
        output fetch_req, fetch_tile, fetch_row, render_start, render_row,
               render_col, busy, line_done, sprite_0_flag, sprite_1_flag
    );

    modport slave (
        output frame_start, line_start, line_row, ppu_ctrl2, fetch_done,
               render_busy, sprite_0_hit_in, sprite_1_hit_in,
        input  fetch_req, fetch_tile, fetch_row, render_start, render_row,
               render_col, busy, line_done, sprite_0_flag, sprite_1_flag
    );
endinterface

// File: rtl/scanline_tile_sequencer.sv
// Walks one scanline as a series of tile fetch + render handshakes and keeps
// sticky per-frame sprite hit flags.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | waiting for an in-range line_start
// FETCH_REQ   | issue fetch_req for the current tile
// FETCH_WAIT  | wait for fetch_done from the load section
// START       | issue render_start with row/column
// WAIT_HI     | wait for the renderer to raise busy (start-to-busy latency)
// WAIT_LO     | renderer running; collect sprite hits until busy drops
// NEXT        | advance tile or finish the line
// DONE        | pulse line_done, drop busy
module scanline_tile_sequencer #(
    parameter int TILES_PER_LINE = 32,
    parameter int TILE_W         = 8,
    parameter int MAX_ROW        = 239
) (
    input logic                        clk,
    input logic                        rst,
    scanline_tile_sequencer_if.master  sif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_TILE = 5'(TILES_PER_LINE - 1);
    localparam logic [8:0] MAX_ROW_W = 9'(MAX_ROW);
    localparam logic [8:0] TILE_W_W  = 9'(TILE_W);

    state_t     state_q;
    logic [4:0] tile_q;
    logic [8:0] row_q;
    logic       fetch_req_q;
    logic [4:0] fetch_tile_q;
    logic [8:0] fetch_row_q;
    logic       render_start_q;
    logic [8:0] render_row_q;
    logic [8:0] render_col_q;
    logic       busy_q;
    logic       line_done_q;
    logic       sprite_0_flag_q;
    logic       sprite_1_flag_q;
    logic       hit_window;
    logic       unused_ctrl2_bits;

    assign unused_ctrl2_bits = ^{sif.ppu_ctrl2[7:5], sif.ppu_ctrl2[2:0]};

    // Hits only count while the renderer is actually drawing this tile.
    assign hit_window = (state_q == S_WAIT_LO) && sif.render_busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            tile_q          <= '0;
            row_q           <= '0;
            fetch_req_q     <= 1'b0;
            fetch_tile_q    <= '0;
            fetch_row_q     <= '0;
            render_start_q  <= 1'b0;
            render_row_q    <= '0;
            render_col_q    <= '0;
            busy_q          <= 1'b0;
            line_done_q     <= 1'b0;
            sprite_0_flag_q <= 1'b0;
            sprite_1_flag_q <= 1'b0;
        end else begin
            fetch_req_q    <= 1'b0;
            render_start_q <= 1'b0;
            line_done_q    <= 1'b0;

            // A hit in the same cycle as frame_start survives the clear.
            sprite_0_flag_q <= (sprite_0_flag_q & ~sif.frame_start)
                             | (hit_window & sif.sprite_0_hit_in);
            sprite_1_flag_q <= (sprite_1_flag_q & ~sif.frame_start)
                             | (hit_window & sif.sprite_1_hit_in);

            case (state_q)
                S_IDLE: begin
                    if (sif.line_start && (sif.line_row <= MAX_ROW_W)) begin
                        row_q  <= sif.line_row;
                        tile_q <= '0;
                        busy_q <= 1'b1;
                        state_q <= (sif.ppu_ctrl2[4:3] == 2'b00) ? S_DONE
                                                                 : S_FETCH_REQ;
                    end
                end
                S_FETCH_REQ: begin
                    fetch_req_q  <= 1'b1;
                    fetch_tile_q <= tile_q;
                    fetch_row_q  <= row_q;
                    state_q      <= S_FETCH_WAIT;
                end
                S_FETCH_WAIT: begin
                    if (sif.fetch_done) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    render_start_q <= 1'b1;
                    render_row_q   <= row_q;
                    render_col_q   <= 9'(tile_q) * TILE_W_W;
                    state_q        <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (sif.render_busy) begin
                        state_q <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!sif.render_busy) begin
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (tile_q == LAST_TILE) begin
                        state_q <= S_DONE;
                    end else begin
                        tile_q  <= tile_q + 5'd1;
                        state_q <= S_FETCH_REQ;
                    end
                end
                S_DONE: begin
                    line_done_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sif.fetch_req     = fetch_req_q;
    assign sif.fetch_tile    = fetch_tile_q;
    assign sif.fetch_row     = fetch_row_q;
    assign sif.render_start  = render_start_q;
    assign sif.render_row    = render_row_q;
    assign sif.render_col    = render_col_q;
    assign sif.busy          = busy_q;
    assign sif.line_done     = line_done_q;
    assign sif.sprite_0_flag = sprite_0_flag_q;
    assign sif.sprite_1_flag = sprite_1_flag_q;

endmodule

// File: tb/tb_scanline_tile_sequencer.sv
// Bench for the scanline tile sequencer: fetch responder, renderer and a
// line-level reference model all advance once per cycle on the falling edge.
module tb_scanline_tile_sequencer;

    localparam int TILES   = 32;
    localparam int TILE_W  = 8;
    localparam int MAX_ROW = 239;

    typedef struct {
        bit is_render;
        int a;
        int b;
    } ev_t;

    logic clk = 1'b0;
    logic rst;

    scanline_tile_sequencer_if sif();

    scanline_tile_sequencer #(
        .TILES_PER_LINE (TILES),
        .TILE_W         (TILE_W),
        .MAX_ROW        (MAX_ROW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    bit rst_req, ls_req, fs_req, rand_mode, fs_on_hit;
    int ls_row;
    int hit0_tile, hit1_tile;

    int fd_cnt, rb_cnt, rlen_cur, h0_at, h1_at, cur_bidx;

    bit  exp_f0, exp_f1, in_line, accept_pend;
    ev_t evq[$];
    int  rcount, ndone, done_cyc, busy_gap, hold_err, last_col;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    endtask

    // One clock: observe DUT outputs, then drive the inputs for the next edge.
    task automatic step();
        bit  fd, bz, h0, h1, fs;
        ev_t e;
        @(negedge clk);
        cyc++;
        if (accept_pend) begin
            in_line     = 1'b1;
            accept_pend = 1'b0;
        end
        check_val("sprite_0_flag", sif.sprite_0_flag, exp_f0);
        check_val("sprite_1_flag", sif.sprite_1_flag, exp_f1);
        if (sif.fetch_req) begin
            e.is_render = 1'b0;
            e.a = int'(sif.fetch_tile);
            e.b = int'(sif.fetch_row);
            evq.push_back(e);
        end
        if (sif.render_start) begin
            e.is_render = 1'b1;
            e.a = int'(sif.render_col);
            e.b = int'(sif.render_row);
            evq.push_back(e);
            rcount++;
            last_col = int'(sif.render_col);
        end else if (rcount != 0 && int'(sif.render_col) != last_col) begin
            hold_err++;
        end
        if (sif.line_done) begin
            ndone++;
            done_cyc = cyc;
        end
        if (in_line && !sif.busy && !sif.line_done) busy_gap++;
        if (sif.line_done) in_line = 1'b0;

        fd = 1'b0;
        if (fd_cnt != 0) begin
            fd_cnt--;
            if (fd_cnt == 0) fd = 1'b1;
        end
        if (sif.fetch_req) fd_cnt = rand_mode ? int'($urandom_range(4, 1)) : 2;

        if (rb_cnt != 0) rb_cnt--;
        if (sif.render_start) begin
            rlen_cur = rand_mode ? int'($urandom_range(9, 2)) : 8;
            rb_cnt   = rlen_cur + 1;
            h0_at    = (rcount - 1 == hit0_tile) ? int'($urandom_range(rlen_cur, 2)) : 0;
            h1_at    = (rcount - 1 == hit1_tile) ? int'($urandom_range(rlen_cur, 2)) : 0;
        end
        bz       = (rb_cnt != 0) && (rb_cnt <= rlen_cur);
        cur_bidx = bz ? rlen_cur + 1 - rb_cnt : 0;
        h0       = bz && (cur_bidx == h0_at);
        h1       = bz && (cur_bidx == h1_at);
        fs       = fs_req || (fs_on_hit && (h0 || h1));
        fs_req   = 1'b0;

        if (!rst_req) begin
            fd_cnt = 0; rb_cnt = 0; cur_bidx = 0; rcount = 0;
            fd = 1'b0; bz = 1'b0; h0 = 1'b0; h1 = 1'b0;
            exp_f0 = 1'b0; exp_f1 = 1'b0;
            in_line = 1'b0; accept_pend = 1'b0;
        end else begin
            if (h0) exp_f0 = 1'b1; else if (fs) exp_f0 = 1'b0;
            if (h1) exp_f1 = 1'b1; else if (fs) exp_f1 = 1'b0;
            if (ls_req && ls_row <= MAX_ROW && !in_line && !accept_pend) accept_pend = 1'b1;
        end

        rst                 = rst_req;
        sif.line_start      = ls_req;
        sif.line_row        = 9'(ls_row);
        sif.frame_start     = fs;
        sif.fetch_done      = fd;
        sif.render_busy     = bz;
        sif.sprite_0_hit_in = h0;
        sif.sprite_1_hit_in = h1;
        ls_req = 1'b0;
    endtask

    task automatic run_line(input int row, input logic [7:0] ctrl, input int extra_at,
                            input string name);
        int ntiles, ls_cyc;
        ntiles = (ctrl[4:3] != 2'b00) ? TILES : 0;
        evq.delete();
        rcount = 0; ndone = 0; busy_gap = 0; hold_err = 0; done_cyc = 0;
        sif.ppu_ctrl2 = ctrl;
        ls_row = row;
        ls_req = 1'b1;
        step();
        ls_cyc = cyc;
        for (int k = 0; k < 4000 && ndone == 0; k++) begin
            if (k == extra_at) begin
                ls_row = (row + 37) % (MAX_ROW + 1);
                ls_req = 1'b1;
            end
            step();
        end
        check_val($sformatf("%s line_done_seen", name), ndone, 1);
        if (ntiles == 0) check_val($sformatf("%s idle_latency", name), done_cyc - ls_cyc, 2);
        repeat (3) step();
        check_val($sformatf("%s line_done_count", name), ndone, 1);
        check_val($sformatf("%s busy_after", name), sif.busy, 0);
        check_val($sformatf("%s busy_gap", name), busy_gap, 0);
        check_val($sformatf("%s col_hold", name), hold_err, 0);
        check_val($sformatf("%s event_count", name), evq.size(), 2 * ntiles);
        for (int i = 0; i < ntiles && 2 * i + 1 < evq.size(); i++) begin
            check_val($sformatf("%s t%0d fetch_tile", name, i),
                      evq[2*i].is_render ? -1 : evq[2*i].a, i);
            check_val($sformatf("%s t%0d fetch_row", name, i), evq[2*i].b, row);
            check_val($sformatf("%s t%0d render_col", name, i),
                      evq[2*i+1].is_render ? evq[2*i+1].a : -1, (i * TILE_W) % 512);
            check_val($sformatf("%s t%0d render_row", name, i), evq[2*i+1].b, row);
        end
    endtask

    task automatic reject_line(input int row);
        evq.delete();
        ndone = 0;
        sif.ppu_ctrl2 = 8'h18;
        ls_row = row;
        ls_req = 1'b1;
        step();
        repeat (4) step();
        check_val($sformatf("reject r%0d busy", row), sif.busy, 0);
        check_val($sformatf("reject r%0d events", row), evq.size(), 0);
        check_val($sformatf("reject r%0d line_done", row), ndone, 0);
    endtask

    initial begin
        int nsave, k, row, xat;
        logic [7:0] ctrl;

        rst = 1'b0;
        rst_req = 1'b0; ls_req = 1'b1; ls_row = 10; fs_req = 1'b1;
        rand_mode = 1'b0; fs_on_hit = 1'b0; hit0_tile = -1; hit1_tile = -1;
        fd_cnt = 0; rb_cnt = 0; rlen_cur = 8; h0_at = 0; h1_at = 0; cur_bidx = 0;
        exp_f0 = 1'b0; exp_f1 = 1'b0; in_line = 1'b0; accept_pend = 1'b0;
        rcount = 0; ndone = 0; done_cyc = 0; busy_gap = 0; hold_err = 0; last_col = 0;
        sif.line_start = 1'b1; sif.line_row = 9'd10; sif.ppu_ctrl2 = 8'hFF;
        sif.frame_start = 1'b0; sif.fetch_done = 1'b1; sif.render_busy = 1'b1;
        sif.sprite_0_hit_in = 1'b1; sif.sprite_1_hit_in = 1'b1;

        // reset while every input is poisoned
        step();
        check_val("rst fetch_req", sif.fetch_req, 0);
        check_val("rst fetch_tile", sif.fetch_tile, 0);
        check_val("rst fetch_row", sif.fetch_row, 0);
        check_val("rst render_start", sif.render_start, 0);
        check_val("rst render_row", sif.render_row, 0);
        check_val("rst render_col", sif.render_col, 0);
        check_val("rst busy", sif.busy, 0);
        check_val("rst line_done", sif.line_done, 0);
        rst_req = 1'b1;
        step();
        step();
        check_val("post-rst busy", sif.busy, 0);
        check_val("post-rst events", evq.size(), 0);

        hit0_tile = 5;
        run_line(10, 8'h18, -1, "lineA");
        check_val("lineA sprite_0_flag", sif.sprite_0_flag, 1);
        hit0_tile = -1;

        run_line(50, 8'h00, -1, "lineOff");
        check_val("lineOff sprite_0_flag kept", sif.sprite_0_flag, 1);

        reject_line(240);
        reject_line(511);

        run_line(20, 8'h10, 60, "lineDup");

        hit0_tile = 3; hit1_tile = 7; fs_on_hit = 1'b1;
        run_line(100, 8'h18, -1, "lineFs");
        check_val("lineFs sprite_0_flag", sif.sprite_0_flag, 0);
        check_val("lineFs sprite_1_flag", sif.sprite_1_flag, 1);
        hit0_tile = -1; hit1_tile = -1; fs_on_hit = 1'b0;

        fs_req = 1'b1;
        step();
        step();
        check_val("lone frame_start flag0", sif.sprite_0_flag, 0);
        check_val("lone frame_start flag1", sif.sprite_1_flag, 0);

        // reset in the middle of tile 12's render
        evq.delete(); rcount = 0; ndone = 0;
        sif.ppu_ctrl2 = 8'h08;
        ls_row = 30;
        ls_req = 1'b1;
        step();
        k = 0;
        while (!(rcount == 13 && cur_bidx == 3) && k < 2000) begin
            step();
            k++;
        end
        check_val("reach tile12", (rcount == 13 && cur_bidx == 3) ? 1 : 0, 1);
        check_val("tile12 render_col", last_col, 12 * TILE_W);
        nsave = evq.size();
        rst_req = 1'b0;
        step();
        step();
        check_val("midrst busy", sif.busy, 0);
        check_val("midrst render_start", sif.render_start, 0);
        check_val("midrst line_done", sif.line_done, 0);
        rst_req = 1'b1;
        ndone = 0;
        repeat (20) step();
        check_val("midrst no line_done", ndone, 0);
        check_val("midrst no activity", evq.size(), nsave);
        run_line(31, 8'h18, -1, "restart");

        rand_mode = 1'b1;
        for (int n = 0; n < 6; n++) begin
            row  = int'($urandom_range(300, 0));
            ctrl = 8'($urandom);
            hit0_tile = int'($urandom_range(40, 0));
            hit1_tile = int'($urandom_range(40, 0));
            fs_on_hit = 1'($urandom_range(1, 0));
            if ($urandom_range(1, 0) == 1) begin
                fs_req = 1'b1;
                step();
            end
            xat = (ctrl[4:3] != 2'b00 && $urandom_range(1, 0) == 1) ? int'($urandom_range(200, 1)) : -1;
            if (row > MAX_ROW) reject_line(row);
            else run_line(row, ctrl, xat, $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
